// File: rtl/kws_cfu_pkg.sv
// Shared types, constants and requantise arithmetic for the KWS CFU.
package kws_cfu_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned FID_W  = 10;
  localparam int unsigned OFF_W  = 9;
  localparam int unsigned EXP_W  = 5;

  localparam logic [DATA_W-1:0] INT32_MIN = 32'h8000_0000;
  localparam logic [DATA_W-1:0] INT32_MAX = 32'h7FFF_FFFF;
  localparam int                INT8_MIN  = -128;
  localparam int                INT8_MAX  = 127;

  typedef enum logic [2:0] {
    OP_MAC     = 3'd0,
    OP_SET_OFF = 3'd1,
    OP_ACC_RD  = 3'd2,
    OP_REQUANT = 3'd3
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_e;

  // Operand pair captured when a command is accepted
  typedef struct packed {
    logic [DATA_W-1:0] in0;
    logic [DATA_W-1:0] in1;
  } cfu_ops_t;

  // One slot of the requantise pipeline after the SRDHM step
  typedef struct packed {
    logic              v;
    logic [DATA_W-1:0] s;
    logic [EXP_W-1:0]  e;
    logic [OFF_W-1:0]  off;
  } rq_stage_t;

  // Saturating rounding doubling high multiply
  function automatic logic [DATA_W-1:0] srdhm(input logic [DATA_W-1:0] x,
                                              input logic [DATA_W-1:0] m);
    logic signed [63:0] p;
    logic signed [63:0] sum;
    if (x == INT32_MIN && m == INT32_MIN) return INT32_MAX;
    p   = $signed({{32{x[31]}}, x}) * $signed({{32{m[31]}}, m});
    sum = p + (p[63] ? -64'sd1073741823 : 64'sd1073741824);
    // bias negative values so the arithmetic shift truncates toward zero
    if (sum[63]) sum = sum + 64'sd2147483647;
    return sum[62:31];
  endfunction

  // Rounding divide by a power of two, ties away from zero
  function automatic logic [DATA_W-1:0] rcdbpot(input logic [DATA_W-1:0] s,
                                                input logic [EXP_W-1:0]  e);
    logic [DATA_W-1:0] mask;
    logic [DATA_W-1:0] r;
    logic [DATA_W-1:0] t;
    mask = (32'd1 << e) - 32'd1;
    r    = s & mask;
    t    = (mask >> 1) + {31'd0, s[31]};
    return 32'($signed(s) >>> e) + ((r > t) ? 32'd1 : 32'd0);
  endfunction

  // Add the output offset and saturate to int8, sign-extended to 32 bits
  function automatic logic [DATA_W-1:0] add_clamp8(input logic [DATA_W-1:0] q,
                                                   input logic [OFF_W-1:0]  off);
    logic [DATA_W:0] sum;
    sum = {q[31], q} + {{(DATA_W+1-OFF_W){off[OFF_W-1]}}, off};
    if ($signed(sum) < -33'sd128) return 32'(INT8_MIN);
    if ($signed(sum) > 33'sd127)  return 32'(INT8_MAX);
    return {{24{sum[7]}}, sum[7:0]};
  endfunction

endpackage

// File: rtl/kws_cfu_pipe_requant.sv
// Requantise pipeline: SRDHM on entry, rounding shift + offset + clamp on exit.
module kws_requant_pipe
  import kws_cfu_pkg::*;
#(
  parameter int unsigned REQ_STAGES = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] x,
  input  logic [DATA_W-1:0] m,
  input  logic [EXP_W-1:0]  e,
  input  logic [OFF_W-1:0]  out_off,
  output logic              out_valid,
  output logic [DATA_W-1:0] y
);

  localparam int unsigned MID = REQ_STAGES - 1;

  rq_stage_t         r_mid [MID];
  logic              r_out_valid;
  logic [DATA_W-1:0] r_y;
  logic [DATA_W-1:0] w_s;

  // SRDHM of the incoming operands
  always_comb begin
    w_s = srdhm(x, m);
  end

  // Stage registers: SRDHM result, delay slots, then the final int8 result
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < MID; i++) r_mid[i] <= '0;
      r_out_valid <= 1'b0;
      r_y         <= '0;
    end else begin
      r_mid[0] <= '{v: in_valid, s: w_s, e: e, off: out_off};
      for (int i = 1; i < MID; i++) r_mid[i] <= r_mid[i-1];
      r_out_valid <= r_mid[MID-1].v;
      r_y         <= add_clamp8(rcdbpot(r_mid[MID-1].s, r_mid[MID-1].e), r_mid[MID-1].off);
    end
  end

  assign out_valid = r_out_valid;
  assign y         = r_y;

endmodule

// File: rtl/kws_cfu_pipe.sv
// KWS CFU: command FSM, accumulator banks, SIMD int8 MAC and requantise launch.
module kws_cfu_pipe
  import kws_cfu_pkg::*;
#(
  parameter int unsigned SIMD_LANES = 4,
  parameter int unsigned NUM_ACC    = 4,
  parameter int unsigned REQ_STAGES = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [FID_W-1:0]  cmd_payload_function_id,
  input  logic [DATA_W-1:0] cmd_payload_inputs_0,
  input  logic [DATA_W-1:0] cmd_payload_inputs_1,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_payload_response_ok,
  output logic [DATA_W-1:0] rsp_payload_outputs_0
);

  localparam int unsigned SEL_W = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1;

  state_e            r_state;
  logic              r_cmd_ready;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_out;
  logic [2:0]        r_funct3;
  logic [SEL_W-1:0]  r_sel;
  logic              r_clr;
  cfu_ops_t          r_ops;
  logic [OFF_W-1:0]  r_in_off;
  logic [OFF_W-1:0]  r_out_off;
  logic [DATA_W-1:0] r_acc [NUM_ACC];

  logic              w_accept;
  logic              w_rq_in_valid;
  logic              w_rq_out_valid;
  logic [DATA_W-1:0] w_rq_y;
  logic [DATA_W-1:0] w_acc_cur;
  logic [DATA_W-1:0] w_dot;
  logic [DATA_W-1:0] w_mac_new;
  logic [9:0]        w_a    [SIMD_LANES];
  logic [16:0]       w_prod [SIMD_LANES];
  logic              w_unused;

  assign w_accept      = cmd_valid && r_cmd_ready;
  assign w_rq_in_valid = w_accept && (cmd_payload_function_id[2:0] == OP_REQUANT);
  assign w_unused      = cmd_payload_function_id[8];

  // Requantise operands enter the pipeline directly at accept
  kws_requant_pipe #(
    .REQ_STAGES (REQ_STAGES)
  ) u_requant (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (w_rq_in_valid),
    .x         (cmd_payload_inputs_0),
    .m         (cmd_payload_inputs_1),
    .e         (cmd_payload_function_id[7:3]),
    .out_off   (r_out_off),
    .out_valid (w_rq_out_valid),
    .y         (w_rq_y)
  );

  // Selected bank read and SIMD dot product with input offset
  always_comb begin
    w_acc_cur = '0;
    w_dot     = '0;
    for (int b = 0; b < NUM_ACC; b++) begin
      if (r_sel == SEL_W'(b)) w_acc_cur = r_acc[b];
    end
    for (int l = 0; l < SIMD_LANES; l++) begin
      w_a[l]    = {{2{r_ops.in0[8*l+7]}}, r_ops.in0[8*l +: 8]} + {r_in_off[OFF_W-1], r_in_off};
      w_prod[l] = {{7{w_a[l][9]}}, w_a[l]} * {{9{r_ops.in1[8*l+7]}}, r_ops.in1[8*l +: 8]};
      w_dot     = w_dot + {{15{w_prod[l][16]}}, w_prod[l]};
    end
    w_mac_new = w_acc_cur + w_dot;
  end

  // Command/response FSM with accumulator and offset state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_cmd_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_out       <= '0;
      r_funct3    <= '0;
      r_sel       <= '0;
      r_clr       <= 1'b0;
      r_ops       <= '0;
      r_in_off    <= '0;
      r_out_off   <= '0;
      for (int b = 0; b < NUM_ACC; b++) r_acc[b] <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_funct3    <= cmd_payload_function_id[2:0];
            r_sel       <= (NUM_ACC > 1) ? cmd_payload_function_id[3 +: SEL_W] : '0;
            r_clr       <= cmd_payload_function_id[9];
            r_ops       <= '{in0: cmd_payload_inputs_0, in1: cmd_payload_inputs_1};
            r_cmd_ready <= 1'b0;
            r_state     <= EXEC;
          end
        end
        EXEC: begin
          r_rsp_valid <= 1'b1;
          r_state     <= RESP;
          case (r_funct3)
            OP_MAC: begin
              for (int b = 0; b < NUM_ACC; b++) begin
                if (r_sel == SEL_W'(b)) r_acc[b] <= w_mac_new;
              end
              r_out <= w_mac_new;
            end
            OP_SET_OFF: begin
              r_in_off  <= r_ops.in0[OFF_W-1:0];
              r_out_off <= r_ops.in1[OFF_W-1:0];
              r_out     <= '0;
            end
            OP_ACC_RD: begin
              for (int b = 0; b < NUM_ACC; b++) begin
                if (r_clr && r_sel == SEL_W'(b)) r_acc[b] <= '0;
              end
              r_out <= w_acc_cur;
            end
            OP_REQUANT: begin
              r_rsp_valid <= 1'b0;
              r_state     <= WAIT;
            end
            default: r_out <= '0;
          endcase
        end
        WAIT: begin
          if (w_rq_out_valid) begin
            r_out       <= w_rq_y;
            r_rsp_valid <= 1'b1;
            r_state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign cmd_ready               = r_cmd_ready;
  assign rsp_valid               = r_rsp_valid;
  assign rsp_payload_outputs_0   = r_out;
  assign rsp_payload_response_ok = 1'b1;

endmodule

// File: tb/tb_kws_cfu_pipe.sv
// Scoreboard bench for kws_cfu_pipe: directed commands, queued expectations.
module tb_kws_cfu_pipe;

  localparam int REQ_STAGES = 3;

  logic        clk;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [9:0]  cmd_payload_function_id;
  logic [31:0] cmd_payload_inputs_0;
  logic [31:0] cmd_payload_inputs_1;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_payload_response_ok;
  logic [31:0] rsp_payload_outputs_0;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [31:0] exp_q  [$];
  string       name_q [$];

  kws_cfu_pipe #(
    .SIMD_LANES (4),
    .NUM_ACC    (4),
    .REQ_STAGES (REQ_STAGES)
  ) dut (
    .clk                     (clk),
    .reset                   (reset),
    .cmd_valid               (cmd_valid),
    .cmd_ready               (cmd_ready),
    .cmd_payload_function_id (cmd_payload_function_id),
    .cmd_payload_inputs_0    (cmd_payload_inputs_0),
    .cmd_payload_inputs_1    (cmd_payload_inputs_1),
    .rsp_valid               (rsp_valid),
    .rsp_ready               (rsp_ready),
    .rsp_payload_response_ok (rsp_payload_response_ok),
    .rsp_payload_outputs_0   (rsp_payload_outputs_0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Monitor: every completed response handshake is matched against the queue
  always @(negedge clk) begin
    if (reset && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got 0x%08h expected no response", rsp_payload_outputs_0);
      end else begin
        check(name_q.pop_front(), rsp_payload_outputs_0, exp_q.pop_front());
        check("rsp_ok", 32'(rsp_payload_response_ok), 32'd1);
      end
    end
  end

  // Issue one command, check latency/busy, optionally stall the response
  task automatic run_op(input string nm, input logic [9:0] fid, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat,
                        input bit hold);
    int n;
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check({nm, "_ready"}, 32'(cmd_ready), 32'd1);
    exp_q.push_back(exp);
    name_q.push_back(nm);
    cmd_valid               = 1'b1;
    cmd_payload_function_id = fid;
    cmd_payload_inputs_0    = a;
    cmd_payload_inputs_1    = b;
    @(posedge clk); #1;
    cmd_valid               = 1'b0;
    cmd_payload_function_id = 10'($urandom());
    cmd_payload_inputs_0    = $urandom();
    cmd_payload_inputs_1    = $urandom();
    n = 0;
    while (!rsp_valid && n < 50) begin
      check({nm, "_busy"}, 32'(cmd_ready), 32'd0);
      @(posedge clk); #1; n++;
    end
    check({nm, "_lat"}, 32'(n), 32'(lat));
    if (hold) begin
      for (int i = 0; i < 5; i++) begin
        check({nm, "_hold_valid"}, 32'(rsp_valid), 32'd1);
        check({nm, "_hold_data"}, rsp_payload_outputs_0, exp);
        check({nm, "_hold_ready"}, 32'(cmd_ready), 32'd0);
        @(posedge clk); #1;
      end
      rsp_ready = 1'b1;
    end
    @(posedge clk); #1;
    check({nm, "_done"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    reset                   = 1'b0;
    cmd_valid               = 1'b0;
    rsp_ready               = 1'b1;
    cmd_payload_function_id = '0;
    cmd_payload_inputs_0    = '0;
    cmd_payload_inputs_1    = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_out", rsp_payload_outputs_0, 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("idle_no_rsp", 32'(rsp_valid), 32'd0);

    // MAC with zero offsets, bank 0
    run_op("set_off0", 10'h001, 32'd0, 32'd0, 32'd0, 1, 1'b0);
    run_op("mac_8", 10'h000, 32'h0101_0101, 32'h0202_0202, 32'd8, 1, 1'b0);
    run_op("mac_16", 10'h000, 32'h0101_0101, 32'h0202_0202, 32'd16, 1, 1'b0);
    run_op("rd_b0", 10'h002, 32'd0, 32'd0, 32'd16, 1, 1'b0);

    // in_off=+128 cancels -128 activations; bank 2 and bank 1 untouched
    run_op("set_off128", 10'h001, 32'd128, 32'h0001_FF80, 32'd0, 1, 1'b0);
    run_op("mac_cancel", 10'h010, 32'h8080_8080, 32'h7F7F_7F7F, 32'd0, 1, 1'b0);
    run_op("rd_b1", 10'h00A, 32'd0, 32'd0, 32'd0, 1, 1'b0);

    // requant: 1000*2^30 -> 500 -> 250 -> 250-128 = 122
    run_op("rq_122", 10'h00B, 32'd1000, 32'h4000_0000, 32'd122, REQ_STAGES, 1'b0);
    run_op("set_off_z", 10'h001, 32'd0, 32'd0, 32'd0, 1, 1'b0);
    run_op("rq_sat", 10'h003, 32'h8000_0000, 32'h8000_0000, 32'd127, REQ_STAGES, 1'b0);
    run_op("rq_neg", 10'h00B, 32'hFFFF_FC18, 32'h4000_0000, 32'hFFFF_FF80, REQ_STAGES, 1'b0);
    run_op("op5", 10'h005, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0, 1, 1'b0);

    // in_off=1, bank 3: 3*2 + 4*(-1) + 0*5 + 1*4 = 6
    run_op("set_off1", 10'h001, 32'd1, 32'd0, 32'd0, 1, 1'b0);
    run_op("mac_mix", 10'h018, 32'h00FF_0302, 32'h0405_FF02, 32'd6, 1, 1'b0);

    // stalled response, then read-and-clear
    rsp_ready = 1'b0;
    run_op("rd_hold", 10'h002, 32'd0, 32'd0, 32'd16, 1, 1'b1);
    run_op("rd_clr", 10'h202, 32'd0, 32'd0, 32'd16, 1, 1'b0);
    run_op("rd_after_clr", 10'h002, 32'd0, 32'd0, 32'd0, 1, 1'b0);

    // reset while a requant is in flight
    cmd_valid               = 1'b1;
    cmd_payload_function_id = 10'h00B;
    cmd_payload_inputs_0    = 32'd1000;
    cmd_payload_inputs_1    = 32'h4000_0000;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    check("wait_busy", 32'(cmd_ready), 32'd0);
    reset = 1'b0;
    #1;
    check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    exp_q.delete();
    name_q.delete();
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      check("no_stale_rsp", 32'(rsp_valid), 32'd0);
      @(posedge clk); #1;
    end
    check("post_rst_ready", 32'(cmd_ready), 32'd1);
    run_op("rd_b3_rst", 10'h01A, 32'd0, 32'd0, 32'd0, 1, 1'b0);
    run_op("mac_after_rst", 10'h000, 32'h0101_0101, 32'h0202_0202, 32'd8, 1, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
